// File: rtl/measurement_sequencer.sv
// ---------------------------------------------------------------------------
// measurement_sequencer
//
// Sequences one amplitude measurement: clears the DSP chain, runs the data
// source for N*M samples, waits for the selected lockin result, then latches
// the amplitude from the amplitude calculator.
//
//   IDLE -> FLUSH -> ACQUIRE -> WAIT_LI -> WAIT_AMP -> DONE -> IDLE
//
// Ports
//   clk, reset_n       : clock, asynchronous active-low reset
//   start, abort       : one-cycle control requests (abort has priority)
//   mode               : 0 = coherent average + lockin, 1 = plain lockin
//   x_valid            : data source sample strobe
//   li_valid           : plain lockin result valid
//   ca_li_valid        : CA+lockin result valid
//   amp_done           : amplitude calculator output ready
//   amp_li, amp_ca_li  : amplitudes for the two paths
//   src_enable         : data source enable (high throughout ACQUIRE)
//   dsp_clr_n          : active-low clear for CA / lockin / amplitude blocks
//   busy, done         : status; done is a single-cycle pulse
//   timeout            : sticky watchdog flag (0 unless watchdog built in)
//   result             : latched amplitude, held until the next DONE
//   sample_count       : saturating count of samples in this acquisition
//
// Build option
//   SEQ_WATCHDOG_EN    : when defined, the time spent in WAIT_LI + WAIT_AMP is
//                        limited to TIMEOUT_CYCLES; expiry returns to IDLE and
//                        sets timeout until the next accepted start.
// ---------------------------------------------------------------------------
module measurement_sequencer #(
  parameter int M              = 32,
  parameter int N              = 32,
  parameter int FLUSH_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        mode,
  input  logic        x_valid,
  input  logic        li_valid,
  input  logic        ca_li_valid,
  input  logic        amp_done,
  input  logic [15:0] amp_li,
  input  logic [15:0] amp_ca_li,
  output logic        src_enable,
  output logic        dsp_clr_n,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] result,
  output logic [31:0] sample_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_ACQUIRE,
    S_WAIT_LI,
    S_WAIT_AMP,
    S_DONE
  } state_e;

  localparam logic [31:0] TOTAL_SAMPLES = 32'(M * N);
  localparam logic [15:0] FLUSH_LAST    = 16'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic        mode_q, mode_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] count_q, count_d;
  logic [15:0] result_q, result_d;
  logic        src_enable_q, src_enable_d;
  logic        dsp_clr_n_q, dsp_clr_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        li_sel_valid;

`ifdef SEQ_WATCHDOG_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;
`endif

  // Only the lockin path chosen at start may advance WAIT_LI.
  assign li_sel_valid = mode_q ? li_valid : ca_li_valid;

  always_comb begin
    // NOTE: every signal written here gets a hold-value default first; a
    // path that leaves one unassigned would infer a latch.
    state_d     = state_q;
    mode_d      = mode_q;
    flush_cnt_d = flush_cnt_q;
    count_d     = count_q;
    result_d    = result_q;
`ifdef SEQ_WATCHDOG_EN
    wd_cnt_d    = wd_cnt_q;
    timeout_d   = timeout_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d      = mode;
          count_d     = '0;
          flush_cnt_d = '0;
`ifdef SEQ_WATCHDOG_EN
          wd_cnt_d    = '0;
          timeout_d   = 1'b0;
`endif
          state_d     = S_FLUSH;
        end
      end

      S_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = S_ACQUIRE;
        end else begin
          flush_cnt_d = flush_cnt_q + 16'd1;
        end
      end

      S_ACQUIRE: begin
        if (x_valid) begin
          if (count_q != '1) begin
            count_d = count_q + 32'd1;
          end
          // The final sample leaves ACQUIRE, which drops src_enable next cycle.
          if (count_d == TOTAL_SAMPLES) begin
            state_d = S_WAIT_LI;
          end
        end
      end

      S_WAIT_LI: begin
        if (li_sel_valid) begin
          state_d = S_WAIT_AMP;
        end
      end

      S_WAIT_AMP: begin
        if (amp_done) begin
          result_d = mode_q ? amp_li : amp_ca_li;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef SEQ_WATCHDOG_EN
    // Watchdog covers both wait states as one budget; expiry overrides any
    // progress seen in the same cycle.
    if (state_q == S_WAIT_LI || state_q == S_WAIT_AMP) begin
      if (wd_cnt_q == WD_LAST) begin
        state_d   = S_IDLE;
        result_d  = result_q;
        timeout_d = 1'b1;
      end else begin
        wd_cnt_d = wd_cnt_q + 32'd1;
      end
    end
`endif

    // Abort beats everything else that could happen in the same cycle.
    if (abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      count_d  = count_q;
      result_d = result_q;
`ifdef SEQ_WATCHDOG_EN
      timeout_d = timeout_q;
`endif
    end

    // Outputs are registered from the next state so they line up with it.
    src_enable_d = (state_d == S_ACQUIRE);
    dsp_clr_n_d  = (state_d != S_FLUSH);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      flush_cnt_q  <= '0;
      count_q      <= '0;
      result_q     <= '0;
      src_enable_q <= 1'b0;
      dsp_clr_n_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wd_cnt_q     <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      mode_q       <= mode_d;
      flush_cnt_q  <= flush_cnt_d;
      count_q      <= count_d;
      result_q     <= result_d;
      src_enable_q <= src_enable_d;
      dsp_clr_n_q  <= dsp_clr_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef SEQ_WATCHDOG_EN
      wd_cnt_q     <= wd_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign src_enable   = src_enable_q;
  assign dsp_clr_n    = dsp_clr_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign sample_count = count_q;

`ifdef SEQ_WATCHDOG_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_measurement_sequencer.sv
// ---------------------------------------------------------------------------
// tb_measurement_sequencer
//
// Directed bench for measurement_sequencer with M=4, N=2 (8 samples),
// FLUSH_CYCLES=4, TIMEOUT_CYCLES=10. Inputs change 1 time unit after a rising
// edge; outputs are read at the same point, i.e. right after the edge that
// sampled the inputs. Watchdog checks follow the SEQ_WATCHDOG_EN build option.
// ---------------------------------------------------------------------------
module tb_measurement_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort, mode, x_valid, li_valid, ca_li_valid, amp_done;
  logic [15:0] amp_li, amp_ca_li;
  logic        src_enable, dsp_clr_n, busy, done, timeout;
  logic [15:0] result;
  logic [31:0] sample_count;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  measurement_sequencer #(
    .M(4), .N(2), .FLUSH_CYCLES(4), .TIMEOUT_CYCLES(10)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .mode(mode),
    .x_valid(x_valid), .li_valid(li_valid), .ca_li_valid(ca_li_valid),
    .amp_done(amp_done), .amp_li(amp_li), .amp_ca_li(amp_ca_li),
    .src_enable(src_enable), .dsp_clr_n(dsp_clr_n), .busy(busy), .done(done),
    .timeout(timeout), .result(result), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  // Counts cycles with done high, sampled mid-cycle.
  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic m);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles with dsp_clr_n low, then returns in ACQUIRE.
  task automatic wait_flush(output int n_low);
    n_low = 0;
    while (dsp_clr_n == 1'b0 && n_low < 20) begin
      n_low++;
      tick();
    end
  endtask

  task automatic feed_samples(input int n);
    x_valid = 1'b1;
    for (int i = 0; i < n; i++) tick();
    x_valid = 1'b0;
  endtask

  int n_low;
  int n_wait;
  int d0;

  initial begin
    reset_n = 1'b0;
    start = 0; abort = 0; mode = 0; x_valid = 0; li_valid = 0;
    ca_li_valid = 0; amp_done = 0; amp_li = '0; amp_ca_li = '0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_clr_n", 32'(dsp_clr_n), 0);
    check("rst_result", 32'(result), 0);
    check("rst_count", sample_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("idle_clr_n", 32'(dsp_clr_n), 1);
    check("idle_src_en", 32'(src_enable), 0);

    // ---- Plain lockin run, x_valid every cycle --------------------------
    do_start(1'b1);
    check("s1_busy", 32'(busy), 1);
    wait_flush(n_low);
    check("s1_flush_len", 32'(n_low), 4);
    check("s1_src_en_on", 32'(src_enable), 1);
    x_valid = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("s1_count7", sample_count, 7);
    check("s1_src_en_7", 32'(src_enable), 1);
    tick();
    check("s1_count8", sample_count, 8);
    check("s1_src_en_off", 32'(src_enable), 0);
    repeat (4) tick();
    x_valid = 1'b0;
    check("s1_count_hold", sample_count, 8);
    li_valid = 1'b1;
    tick();
    li_valid = 1'b0;
    amp_li = 16'h1234; amp_ca_li = 16'h4321; amp_done = 1'b1;
    tick();
    amp_done = 1'b0;
    check("s1_done", 32'(done), 1);
    check("s1_result", 32'(result), 32'h1234);
    tick();
    check("s1_done_1cyc", 32'(done), 0);
    check("s1_idle", 32'(busy), 0);

    // ---- CA path; non-selected valid and later mode flip ignored --------
    do_start(1'b0);
    mode = 1'b1;
    wait_flush(n_low);
    feed_samples(8);
    check("s2_count", sample_count, 8);
    d0 = done_cnt;
    amp_li = 16'hFFFF; amp_ca_li = 16'h00AB;
    li_valid = 1'b1;
    tick();
    li_valid = 1'b0;
    amp_done = 1'b1;
    tick();
    amp_done = 1'b0;
    check("s2_li_ignored", 32'(done_cnt - d0), 0);
    check("s2_still_busy", 32'(busy), 1);
    ca_li_valid = 1'b1;
    tick();
    ca_li_valid = 1'b0;
    amp_done = 1'b1;
    tick();
    amp_done = 1'b0;
    check("s2_done", 32'(done), 1);
    check("s2_result", 32'(result), 32'h00AB);
    tick();

    // ---- Abort with start at the third sample ---------------------------
    do_start(1'b1);
    wait_flush(n_low);
    d0 = done_cnt;
    feed_samples(2);
    x_valid = 1'b1; abort = 1'b1; start = 1'b1;
    tick();
    x_valid = 1'b0; abort = 1'b0; start = 1'b0;
    check("s3_busy", 32'(busy), 0);
    check("s3_src_en", 32'(src_enable), 0);
    check("s3_count", sample_count, 2);
    check("s3_result", 32'(result), 32'h00AB);
    repeat (3) tick();
    check("s3_stay_idle", 32'(busy), 0);
    check("s3_no_done", 32'(done_cnt - d0), 0);

    // ---- Reset during WAIT_AMP, then a clean run ------------------------
    do_start(1'b1);
    wait_flush(n_low);
    feed_samples(8);
    li_valid = 1'b1;
    tick();
    li_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("s4_busy", 32'(busy), 0);
    check("s4_clr_n", 32'(dsp_clr_n), 0);
    check("s4_done", 32'(done), 0);
    check("s4_src_en", 32'(src_enable), 0);
    check("s4_result", 32'(result), 0);
    check("s4_count", sample_count, 0);
    check("s4_timeout", 32'(timeout), 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("s4_clr_n_up", 32'(dsp_clr_n), 1);
    do_start(1'b1);
    wait_flush(n_low);
    check("s4_flush_len", 32'(n_low), 4);
    feed_samples(8);
    li_valid = 1'b1;
    tick();
    li_valid = 1'b0;
    amp_li = 16'h5A5A; amp_done = 1'b1;
    tick();
    amp_done = 1'b0;
    check("s4_done_after", 32'(done), 1);
    check("s4_result_after", 32'(result), 32'h5A5A);
    tick();

    // ---- Sparse samples, start during ACQUIRE ---------------------------
    do_start(1'b0);
    wait_flush(n_low);
    check("s6_flush_len", 32'(n_low), 4);
    n_wait = 0;
    while (src_enable && n_wait < 100) begin
      x_valid = (n_wait % 3 == 2);
      start   = (n_wait == 4);
      tick();
      n_wait++;
    end
    x_valid = 1'b0; start = 1'b0;
    check("s6_cycles", 32'(n_wait), 24);
    check("s6_count", sample_count, 8);
    check("s6_busy", 32'(busy), 1);
    ca_li_valid = 1'b1; amp_ca_li = 16'h0777; amp_done = 1'b1;
    tick();
    ca_li_valid = 1'b0;
    tick();
    amp_done = 1'b0;
    check("s6_result", 32'(result), 32'h0777);
    tick();
    check("s6_idle", 32'(busy), 0);

    // ---- Lockin result never arrives ------------------------------------
    do_start(1'b1);
    wait_flush(n_low);
    feed_samples(8);
    d0 = done_cnt;
`ifdef SEQ_WATCHDOG_EN
    n_wait = 0;
    while (busy && n_wait < 50) begin
      tick();
      n_wait++;
    end
    check("s5_wd_cycles", 32'(n_wait), 10);
    check("s5_timeout", 32'(timeout), 1);
    check("s5_no_done", 32'(done_cnt - d0), 0);
    repeat (2) tick();
    check("s5_sticky", 32'(timeout), 1);
    do_start(1'b1);
    check("s5_cleared", 32'(timeout), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`else
    repeat (30) tick();
    check("s5_wait_busy", 32'(busy), 1);
    check("s5_timeout0", 32'(timeout), 0);
    check("s5_no_done", 32'(done_cnt - d0), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`endif
    check("s5_idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/measurement_sequencer.md
MEASUREMENT_SEQUENCER -- requirements
Module: measurement_sequencer

Interface
REQ-001 SHALL have parameter M, default 32, samples per reference period.
REQ-002 SHALL have parameter N, default 32, reference periods per measurement; acquisition length is N*M samples.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 4, datapath clear duration in clk cycles.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 65535, watchdog limit in clk cycles.
REQ-005 SHALL have port clk  input  1  single clock for all logic.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a measurement.
REQ-008 SHALL have port abort  input  1  one-cycle request to cancel a measurement.
REQ-009 SHALL have port mode  input  1  0 = coherent average + lockin path, 1 = plain lockin path.
REQ-010 SHALL have port x_valid  input  1  data source sample strobe.
REQ-011 SHALL have port li_valid  input  1  plain lockin result valid.
REQ-012 SHALL have port ca_li_valid  input  1  CA+lockin result valid.
REQ-013 SHALL have port amp_done  input  1  amplitude calculator output ready.
REQ-014 SHALL have port amp_li  input  16  plain lockin amplitude.
REQ-015 SHALL have port amp_ca_li  input  16  CA+lockin amplitude.
REQ-016 SHALL have port src_enable  output  1  enables the data source.
REQ-017 SHALL have port dsp_clr_n  output  1  active-low clear driven to the CA, lockin and amplitude blocks.
REQ-018 SHALL have ports busy, done and timeout  output  1 each  status flags.
REQ-019 SHALL have port result  output  16  latched amplitude.
REQ-020 SHALL have port sample_count  output  32  source samples counted in the current acquisition.

Function
REQ-021 SHALL implement the states IDLE, FLUSH, ACQUIRE, WAIT_LI, WAIT_AMP and DONE.
REQ-022 SHALL, in IDLE on start=1, latch mode, clear sample_count and the flush counter, clear timeout, and enter FLUSH.
REQ-023 SHALL, in FLUSH, drive dsp_clr_n=0 for exactly FLUSH_CYCLES cycles and then enter ACQUIRE.
REQ-024 SHALL, in ACQUIRE, drive src_enable=1 and increment sample_count on each x_valid=1 cycle.
REQ-025 SHALL, on the x_valid that brings sample_count to N*M, deassert src_enable in the next cycle and enter WAIT_LI; no further samples are counted.
REQ-026 SHALL, in WAIT_LI, wait for li_valid when latched mode=1 or ca_li_valid when mode=0, then enter WAIT_AMP; the non-selected valid is ignored.
REQ-027 SHALL treat a valid already asserted on the WAIT_LI entry cycle as accepted.
REQ-028 SHALL, in WAIT_AMP, on the first cycle amp_done=1, latch amp_li (mode=1) or amp_ca_li (mode=0) into result and enter DONE.
REQ-029 SHALL, in DONE, assert done=1 for exactly one cycle, then return to IDLE; result holds until the next DONE.
REQ-030 SHALL assert busy=1 in every state except IDLE.
REQ-031 SHALL ignore start while busy=1, and SHALL ignore mode changes after start is accepted.
REQ-032 SHALL, on abort=1 in any non-IDLE state, return to IDLE next cycle with src_enable=0, done=0 and result unchanged; abort wins over a simultaneous start, x_valid or valid.
REQ-033 SHALL keep sample_count 32 bits wide, saturating rather than wrapping.

Reset
REQ-034 SHALL, while reset_n=0 (asynchronous, including mid-operation), force state IDLE, src_enable=0, dsp_clr_n=0, busy=0, done=0, timeout=0, result=0 and sample_count=0.
REQ-035 SHALL drive dsp_clr_n=1 in IDLE after reset release, and in every state other than FLUSH.

Configuration
REQ-036 SHALL, with SEQ_WATCHDOG_EN defined, count cycles spent in WAIT_LI plus WAIT_AMP; on reaching TIMEOUT_CYCLES it goes to IDLE without done and sets timeout=1, which stays set until the next accepted start.
REQ-037 SHALL, without SEQ_WATCHDOG_EN, wait indefinitely in WAIT_LI and WAIT_AMP, drive timeout constantly 0, and include no watchdog counter.

Verification
REQ-038 SHALL test: M=4, N=2, mode=1, x_valid every cycle, li_valid 5 cycles after the last sample, amp_done with amp_li=0x1234 -> exactly 8 samples counted, one-cycle done, result=0x1234.
REQ-039 SHALL test: mode=0, both li_valid and ca_li_valid pulsed, amp_ca_li=0x00AB, amp_li=0xFFFF -> result=0x00AB.
REQ-040 SHALL test: abort at sample 3 of 8 together with start -> IDLE next cycle, src_enable=0, no done, result unchanged.
REQ-041 SHALL test: reset_n pulsed low during WAIT_AMP -> all outputs at reset values immediately; a later start runs a full clean measurement.
REQ-042 SHALL test: SEQ_WATCHDOG_EN defined, TIMEOUT_CYCLES=10, li_valid never arrives -> timeout=1 after 10 cycles in WAIT_LI, no done; the next start clears timeout.
REQ-043 SHALL test: start pulsed during ACQUIRE, and x_valid gated to every third cycle -> start ignored, sample_count reaches N*M exactly, FLUSH dsp_clr_n low for exactly 4 cycles.
